lcd_nibble_writer: RTL

- Memory-mapped bus responder that drives the 6-pin HD44780 character LCD in 4-bit mode: `lcd[3:0]` is D7..D4, `lcd[4]` is RS, `lcd[5]` is E.
- The CPU writes a byte plus RS flag. The block sends high nibble then low nibble, each with setup/E-pulse/hold timing, then waits out the LCD execution time.
- Sits in `top` beside the GPIO ports; `top` decodes the address window and asserts `busValid`.

---
 rtl/lcd_nibble_writer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: bus-mapped HD44780 driver for 4-bit mode.
// A DATA write (byte, RS, single-nibble flag) is sent as high and then low
// nibble. Each nibble gets setup, an E pulse and a hold time. The block then
// waits out the LCD execution time. STATUS reports {overrun, busy}.
// lcd = {E, RS, D7..D4}. E comes from a flop, so it cannot glitch.
module lcd_nibble_writer #(
    parameter int SETUP_CYCLES     = 4,
    parameter int PULSE_CYCLES     = 16,
    parameter int HOLD_CYCLES      = 4,
    parameter int WAIT_CYCLES      = 2500,
    parameter int LONG_WAIT_CYCLES = 85000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busValid,
    input  logic        busWriteEnable,
    input  logic        address,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        busReady,
    output logic [5:0]  lcd,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    // Each timed state loads "length - 1" and leaves when the count reaches zero.
    localparam logic [19:0] SETUP_LOAD = 20'(SETUP_CYCLES - 1);
    localparam logic [19:0] PULSE_LOAD = 20'(PULSE_CYCLES - 1);
    localparam logic [19:0] HOLD_LOAD  = 20'(HOLD_CYCLES - 1);
    localparam logic [19:0] WAIT_LOAD  = 20'(WAIT_CYCLES - 1);
    localparam logic [19:0] LONG_LOAD  = 20'(LONG_WAIT_CYCLES - 1);

    state_t      state_q,    state_d;
    logic [19:0] cnt_q,      cnt_d;
    logic [7:0]  byte_q,     byte_d;
    logic        rs_q,       rs_d;
    logic        single_q,   single_d;
    logic        phase_hi_q, phase_hi_d;
    logic [5:0]  lcd_q,      lcd_d;
    logic        overrun_q,  overrun_d;
    logic        ready_q,    ready_d;
    logic [31:0] dout_q,     dout_d;

    logic wr_data;
    logic rd_status;
    logic long_cmd;
    logic unused_data_bits;

    assign busy      = (state_q != ST_IDLE);
    assign lcd       = lcd_q;
    assign busReady  = ready_q;
    assign dataOut   = dout_q;
    assign wr_data   = busValid &&  busWriteEnable && !address;
    assign rd_status = busValid && !busWriteEnable &&  address;

    // Clear and home need the long execution wait. This applies only when the
    // full byte was sent as a command.
    assign long_cmd = !rs_q && !single_q && (byte_q == 8'h01 || byte_q == 8'h02);

    // Only byte, RS and mode carry meaning in a DATA write.
    assign unused_data_bits = ^dataIn[31:10];

    // Next-state logic for the bus responder and the nibble sequencer.
    always_comb begin
        // NOTE: every _d gets a default first, so no path can leave a value unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        rs_d       = rs_q;
        single_d   = single_q;
        phase_hi_d = phase_hi_q;
        lcd_d      = lcd_q;
        overrun_d  = overrun_q;
        ready_d    = busValid;
        dout_d     = dout_q;

        // Any access updates dataOut on the edge that raises busReady. Only a
        // STATUS read returns something other than zero.
        if (busValid) begin
            dout_d = '0;
            if (rd_status) begin
                dout_d    = {30'b0, overrun_q, busy};
                overrun_d = 1'b0;
            end
        end

        // A write that arrives while busy is dropped and sets the sticky overrun flag.
        if (wr_data && busy) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wr_data) begin
                    byte_d     = dataIn[7:0];
                    rs_d       = dataIn[8];
                    single_d   = dataIn[9];
                    phase_hi_d = 1'b1;
                    lcd_d      = {1'b0, dataIn[8], dataIn[7:4]};
                    cnt_d      = SETUP_LOAD;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    lcd_d[5] = 1'b1;
                    cnt_d    = PULSE_LOAD;
                    state_d  = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    lcd_d[5] = 1'b0;
                    cnt_d    = HOLD_LOAD;
                    state_d  = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    if (phase_hi_q && !single_q) begin
                        phase_hi_d = 1'b0;
                        lcd_d[3:0] = byte_q[3:0];
                        cnt_d      = SETUP_LOAD;
                        state_d    = ST_SETUP;
                    end else begin
                        cnt_d   = long_cmd ? LONG_LOAD : WAIT_LOAD;
                        state_d = ST_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 20'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. Reset acts at once, so E drops without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_q     <= '0;
            rs_q       <= 1'b0;
            single_q   <= 1'b0;
            phase_hi_q <= 1'b0;
            lcd_q      <= '0;
            overrun_q  <= 1'b0;
            ready_q    <= 1'b0;
            dout_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop see the pre-edge values of the others.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            rs_q       <= rs_d;
            single_q   <= single_d;
            phase_hi_q <= phase_hi_d;
            lcd_q      <= lcd_d;
            overrun_q  <= overrun_d;
            ready_q    <= ready_d;
            dout_q     <= dout_d;
        end
    end

endmodule
